// File: rtl/pwm_cfg_write_arbiter.sv
// Round-robin write arbiter that owns the PWM configuration register file (regs 0x00-0x04).
// Optional write-lock register at 0x05 is enabled by defining PWM_CFG_WRITE_LOCK_EN.
module pwm_cfg_write_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int MAX_ADDR   = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] en_reg_out_7_0,
    output logic [DATA_W-1:0] en_reg_out_15_8,
    output logic [DATA_W-1:0] en_reg_pwm_7_0,
    output logic [DATA_W-1:0] en_reg_pwm_15_8,
    output logic [DATA_W-1:0] pwm_duty_cycle,
    output logic              wr_done,
    output logic              wr_err,
    output logic              busy
);

    localparam int NUM_REGS = 5;
    localparam int CNT_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t            state_reg;
    logic              ptr_reg;     // 0: A wins a tie next, 1: B wins a tie next
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              done_reg;
    logic              err_reg;

    logic grant_a;
    logic grant_b;
    logic in_range;
    logic accept;
    logic commit;

    logic [NUM_REGS-1:0][DATA_W-1:0] cfg_bus;

    assign grant_a = a_valid & (~b_valid | ~ptr_reg);
    assign grant_b = b_valid & (~a_valid |  ptr_reg);

    // Ready is held low while reset is asserted so it matches the reset state of the port.
    assign a_ready = ~rst & (state_reg == IDLE) & grant_a;
    assign b_ready = ~rst & (state_reg == IDLE) & grant_b;

    assign in_range = (addr_reg <= ADDR_W'(MAX_ADDR));

`ifdef PWM_CFG_WRITE_LOCK_EN
    logic src_reg;
    logic lock_reg;
    logic is_lock_addr;

    assign is_lock_addr = (addr_reg == ADDR_W'(5));
    // A may always write (including the lock itself); B only while unlocked and never the lock.
    assign accept = src_reg ? (in_range & ~lock_reg) : (in_range | is_lock_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_reg <= 1'b0;
        end else if (a_ready | b_ready) begin
            src_reg <= b_ready;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_reg <= 1'b0;
        end else if ((state_reg == WRITE) && !src_reg && is_lock_addr) begin
            lock_reg <= data_reg[0];
        end
    end
`else
    assign accept = in_range;
`endif

    assign commit = (state_reg == WRITE) & accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_cfg
            logic [DATA_W-1:0] val_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val_reg <= '0;
                end else if (commit && (addr_reg == ADDR_W'(gi))) begin
                    val_reg <= data_reg;
                end
            end
            assign cfg_bus[gi] = val_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (a_ready | b_ready) begin
                        addr_reg  <= a_ready ? a_addr : b_addr;
                        data_reg  <= a_ready ? a_data : b_data;
                        ptr_reg   <= a_ready;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    done_reg <= accept;
                    err_reg  <= ~accept;
                    if (GAP_CYCLES > 0) begin
                        cnt_reg   <= GAP_LOAD;
                        state_reg <= COOL;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                COOL: begin
                    if (cnt_reg == '0) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = cfg_bus[0];
    assign en_reg_out_15_8 = cfg_bus[1];
    assign en_reg_pwm_7_0  = cfg_bus[2];
    assign en_reg_pwm_15_8 = cfg_bus[3];
    assign pwm_duty_cycle  = cfg_bus[4];
    assign wr_done         = done_reg;
    assign wr_err          = err_reg;
    assign busy            = (state_reg != IDLE);

endmodule

// File: doc/pwm_cfg_write_arbiter.md
Name: pwm_cfg_write_arbiter

Overview:
- Owns the PWM configuration register file inside tt_um_uw_onboarding_joshua_ma.
- Arbitrates register writes between two requesters: port A (SPI peripheral decoder) and port B (on-chip sequencer/test source).
- Round-robin grant, one write in flight, enforced cooldown between commits so the PWM core never sees back-to-back config changes.
- Drives the five config registers consumed by the PWM core, plus done/error status pulses.

Parameters:
- ADDR_W, 7, register address width (matches SPI address field).
- DATA_W, 8, register data width.
- MAX_ADDR, 4, highest valid register address; higher addresses are rejected.
- GAP_CYCLES, 2, idle cycles forced after each commit before the next grant (0 allowed).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  requester A write request.
- a_ready  out  1  requester A accepted.
- a_addr  in  ADDR_W  requester A register address.
- a_data  in  DATA_W  requester A write data.
- b_valid  in  1  requester B write request.
- b_ready  out  1  requester B accepted.
- b_addr  in  ADDR_W  requester B register address.
- b_data  in  DATA_W  requester B write data.
- en_reg_out_7_0  out  8  reg 0x00.
- en_reg_out_15_8  out  8  reg 0x01.
- en_reg_pwm_7_0  out  8  reg 0x02.
- en_reg_pwm_15_8  out  8  reg 0x03.
- pwm_duty_cycle  out  8  reg 0x04.
- wr_done  out  1  one-cycle pulse: write committed.
- wr_err  out  1  one-cycle pulse: write rejected.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous, active-high.
- Reset values:
  - All five config registers = 0x00.
  - a_ready, b_ready, wr_done, wr_err, busy = 0.
  - FSM = IDLE; round-robin pointer = A.
- FSM states: IDLE, WRITE, COOL.
- Handshake:
  - Transfer occurs on a cycle with x_valid & x_ready.
  - Ready is combinational and asserted only in IDLE, to exactly one requester.
  - Requester holds valid/addr/data stable until ready is seen.
  - valid dropping before ready is permitted; no request is recorded.
- IDLE:
  - Only one valid: that requester is granted regardless of pointer.
  - Both valid: the pointer side is granted.
  - After any grant, the pointer moves to the other requester.
  - On grant, capture addr/data and go to WRITE. No valid: stay in IDLE.
- WRITE (one cycle):
  - If addr <= MAX_ADDR, the addressed register is loaded at the end of this cycle.
  - Otherwise the register file is unchanged.
  - Next state: COOL if GAP_CYCLES > 0, else IDLE.
- Status pulses:
  - wr_done (valid write) or wr_err (invalid write) is registered and high for exactly the one cycle after WRITE.
  - That is the same cycle the new register value is first visible.
  - wr_done and wr_err are never high together.
- COOL: count down GAP_CYCLES cycles, then IDLE.
- Latency and throughput:
  - Handshake in cycle N; new value and wr_done visible in cycle N+2.
  - Next grant no earlier than cycle N+2+GAP_CYCLES.
- Address compare uses the full ADDR_W bits; no aliasing (0x44 is invalid).
- busy = (state != IDLE).
- Reset mid-operation: any captured write is discarded without a register update, and no done/err pulse is emitted.

Optional Feature:
- Macro: PWM_CFG_WRITE_LOCK_EN.
- Defined:
  - Adds lock register at address 0x05, bit 0 only; reset 0. The range check accepts addr <= MAX_ADDR or addr == 0x05.
  - 0x05 is writable only from A. A B write to 0x05 gives wr_err.
  - While lock = 1, every B write gives wr_err and leaves the register file unchanged. A writes are unaffected.
  - Grant, timing and pointer behaviour are unchanged.
- Undefined: address 0x05 is out of range (wr_err for both requesters); no lock state exists.

Test Plan:
- Reset, then A writes addr 0x04 data 0x80 -> a_ready high same cycle as a_valid; pwm_duty_cycle = 0x80 and wr_done = 1 exactly two cycles after handshake.
- A and B both valid in IDLE after reset (A: 0x00 = 0xFF, B: 0x02 = 0x0F) -> A granted first, B granted 2+GAP_CYCLES = 4 cycles later; final en_reg_out_7_0 = 0xFF, en_reg_pwm_7_0 = 0x0F.
- B writes addr 0x07 data 0x55 -> wr_err single pulse, wr_done stays 0, all registers unchanged.
- Hold both valid continuously for 6 grants -> grants alternate A, B, A, B, A, B; a_ready/b_ready never high together; no ready while busy.
- Assert rst in WRITE state of an A write to 0x03 = 0xAA -> en_reg_pwm_15_8 = 0x00, no wr_done; next simultaneous request is granted to A.
- (PWM_CFG_WRITE_LOCK_EN) A writes 0x05 = 0x01, then B writes 0x04 = 0x33 -> wr_err, pwm_duty_cycle unchanged; A writes 0x04 = 0x33 -> wr_done, pwm_duty_cycle = 0x33.
